pte_mem_responder: RTL and testbench

Memory-side responder for the page-table walker's PTE accesses. Accepts single-word PTE read and write requests (L1/L0 PTE fetch, A/D-bit write-back), forwards them to the DRAM/cache port, and returns the busy/data handshake the walker samples. It sits between the walker and the memory arbiter. An optional one-entry PTE buffer can short-circuit repeated reads.

---
 rtl/pte_mem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_pte_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pte_mem_responder.sv
// ---------------------------------------------------------------------------
// pte_mem_responder
//
// Memory-side responder for the page-table walker's PTE accesses. Takes one
// single-word PTE read or write from the walker, forwards it to the memory
// arbiter port, and returns the busy/data handshake the walker samples.
// Misaligned requests are rejected without touching memory. A memory access
// that is never acknowledged is aborted after MEM_TIMEOUT cycles
// (MEM_TIMEOUT = 0 waits forever).
//
// Optional feature (macro PTE_BUF_EN): a one-entry PTE buffer that answers a
// repeated read of the same word without a memory access. It is filled by
// completed memory reads, updated by writes to the same word, and cleared by
// i_flush. With the macro undefined there is no buffer and i_flush is ignored.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   i_req/i_we        walker request strobe and write select
//   i_addr/i_wdata    PTE byte address and write data, sampled with i_req
//   i_flush           invalidate the PTE buffer (sfence.vma / satp write)
//   o_busy            request in progress
//   o_rdata           last read PTE (0 after an error)
//   o_err             one-cycle pulse: misaligned address or timeout
//   o_mem_*           memory request, held stable until i_mem_ack
//   i_mem_ack/rdata   memory completion and read data
// ---------------------------------------------------------------------------
module pte_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic [31:0]           o_rdata,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_DONE
    } state_t;

    // Last counter value before the abort fires: MEM_TIMEOUT MEM cycles total.
    localparam bit         TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [7:0] TO_LAST = (MEM_TIMEOUT > 0) ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    buf_hit;

`ifdef PTE_BUF_EN
    logic                    buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-3:0]   buf_tag_q, buf_tag_d;
    logic [31:0]             buf_data_q, buf_data_d;

    // A flush in the same cycle as the request wins, so the request misses.
    assign buf_hit = buf_valid_q && !i_flush && !i_we &&
                     (buf_tag_q == i_addr[ADDR_WIDTH-1:2]);
`else
    logic unused_flush;
    assign unused_flush = i_flush;
    assign buf_hit      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
`ifdef PTE_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        // Cleared first; a fill later in this cycle carries fresh memory data.
        if (i_flush) begin
            buf_valid_d = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    busy_d = 1'b1;
                    if (i_addr[1:0] != 2'b00) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (buf_hit) begin
                        state_d = S_DONE;
`ifdef PTE_BUF_EN
                        rdata_d = buf_data_q;
`endif
                    end else begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_we;
                        mem_addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = i_wdata;
                        cnt_d       = 8'd0;
                    end
                end
            end

            S_MEM: begin
                // An ack in the last allowed cycle still completes normally.
                if (i_mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = i_mem_rdata;
                    end
`ifdef PTE_BUF_EN
                    if (!mem_we_q) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = mem_addr_q[ADDR_WIDTH-1:2];
                        buf_data_d  = i_mem_rdata;
                    end else if (buf_tag_q == mem_addr_q[ADDR_WIDTH-1:2]) begin
                        buf_data_d  = mem_wdata_q;
                    end
`endif
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = 32'd0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cnt_q       <= 8'd0;
`ifdef PTE_BUF_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
`ifdef PTE_BUF_EN
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign o_busy      = busy_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_pte_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_pte_mem_responder
//
// Directed and randomized transactions against pte_mem_responder built with
// MEM_TIMEOUT = 4. A transaction-level model (expected rdata, error, busy
// length, memory-request length, one-entry buffer contents) predicts every
// result; one line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_pte_mem_responder;

    localparam int AW  = 32;
    localparam int TMO = 4;
`ifdef PTE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_req = 1'b0;
    logic          i_we = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_wdata = '0;
    logic          i_flush = 1'b0;
    logic          o_busy;
    logic [31:0]   o_rdata;
    logic          o_err;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          i_mem_ack = 1'b0;
    logic [31:0]   i_mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state.
    logic [31:0] m_rdata     = 32'd0;
    bit          m_buf_valid = 1'b0;
    logic [29:0] m_buf_word  = '0;
    logic [31:0] m_buf_data  = 32'd0;

    pte_mem_responder #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One walker transaction. ack_k = cycle (1..) in which i_mem_ack is high,
    // 0 = never. Outputs are sampled on falling edges; cycle 1 is the cycle
    // after the one in which i_req is high.
    task automatic txn(input string name, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_k,
                       input logic [31:0] ack_data, input bit flush, input bit extra_req);
        bit  misal, hit, to_mem, timeout;
        int  exp_busy_end, exp_mem_cycles, exp_err_cycle;
        int  busy_end, mem_cycles, err_cycles, err_cycle, unstable;
        logic [31:0] exp_rdata;

        // Predict.
        if (flush) m_buf_valid = 1'b0;
        misal   = (addr[1:0] != 2'b00);
        hit     = BUF_EN && !misal && !we && m_buf_valid && (m_buf_word == addr[31:2]);
        to_mem  = !misal && !hit;
        timeout = to_mem && (ack_k == 0 || ack_k > TMO);
        if (misal) begin
            exp_rdata = 32'd0; exp_busy_end = 2; exp_mem_cycles = 0; exp_err_cycle = 1;
        end else if (hit) begin
            exp_rdata = m_buf_data; exp_busy_end = 2; exp_mem_cycles = 0; exp_err_cycle = 0;
        end else if (timeout) begin
            exp_rdata = 32'd0; exp_busy_end = TMO + 2; exp_mem_cycles = TMO; exp_err_cycle = TMO + 1;
        end else begin
            exp_rdata = we ? m_rdata : ack_data;
            exp_busy_end = ack_k + 2; exp_mem_cycles = ack_k; exp_err_cycle = 0;
        end

        // Drive and observe.
        @(negedge CLK);
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_flush = flush;
        @(negedge CLK);
        i_flush = 1'b0;
        i_req   = extra_req;              // arrives while busy: must be ignored
        i_addr  = addr ^ 32'h0000_0040;
        i_wdata = ~wdata;
        i_we    = ~we;
        busy_end = 0; mem_cycles = 0; err_cycles = 0; err_cycle = 0; unstable = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(negedge CLK);
                i_req = 1'b0;
            end
            if (o_err) begin err_cycles++; err_cycle = c; end
            if (o_mem_req) begin
                mem_cycles++;
                if (o_mem_we !== we || o_mem_addr !== {addr[31:2], 2'b00} ||
                    (we && o_mem_wdata !== wdata)) unstable++;
            end
            if (!o_busy) begin busy_end = c; break; end
            i_mem_ack   = (c == ack_k);
            i_mem_rdata = (c == ack_k) ? ack_data : $urandom;
        end
        i_mem_ack = 1'b0;

        chk({name, ".busy_end"},   busy_end,   exp_busy_end);
        chk({name, ".mem_cycles"}, mem_cycles, exp_mem_cycles);
        chk({name, ".mem_fields"}, unstable,   0);
        chk({name, ".err_cycles"}, err_cycles, (exp_err_cycle != 0) ? 1 : 0);
        chk({name, ".err_cycle"},  err_cycle,  exp_err_cycle);
        chk({name, ".rdata"},      o_rdata,    exp_rdata);

        // Update the model.
        m_rdata = exp_rdata;
        if (to_mem && !timeout) begin
            if (!we) begin
                m_buf_valid = 1'b1; m_buf_word = addr[31:2]; m_buf_data = ack_data;
            end else if (m_buf_valid && m_buf_word == addr[31:2]) begin
                m_buf_data = wdata;
            end
        end
        $display("txn %-10s we=%0d addr=%08h ack_k=%0d flush=%0d -> %s rdata=%08h busy_end=%0d",
                 name, we, addr, ack_k, flush,
                 misal ? "misaligned" : hit ? "buffer-hit" : timeout ? "timeout" : "memory",
                 o_rdata, busy_end);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("reset.busy",    o_busy,    0);
        chk("reset.rdata",   o_rdata,   0);
        chk("reset.err",     o_err,     0);
        chk("reset.mem_req", o_mem_req, 0);
        chk("reset.mem_we",  o_mem_we,  0);
        chk("reset.mem_addr", o_mem_addr, 0);

        // Directed steps from the feature list.
        txn("rd_ack3",  1'b0, 32'h8000_1004, 32'h0,          3, 32'h2000_0C01, 1'b0, 1'b0);
        txn("wr_ack1",  1'b1, 32'h8000_1004, 32'h2000_0CC1,  1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        txn("rd_again", 1'b0, 32'h8000_1004, 32'h0,          2, 32'h1111_2222, 1'b0, 1'b0);
        txn("flush_rd", 1'b0, 32'h8000_1004, 32'h0,          1, 32'h3333_4444, 1'b1, 1'b0);
        txn("misalign", 1'b0, 32'h8000_1006, 32'h0,          1, 32'h5555_6666, 1'b0, 1'b0);
        txn("timeout",  1'b0, 32'h8000_2000, 32'h0,          0, 32'h0,         1'b0, 1'b0);

        // Stray ack after the timeout must be ignored.
        @(negedge CLK);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        @(negedge CLK);
        i_mem_ack = 1'b0;
        @(negedge CLK);
        chk("stray.busy",    o_busy,    0);
        chk("stray.mem_req", o_mem_req, 0);
        chk("stray.rdata",   o_rdata,   0);
        chk("stray.err",     o_err,     0);

        // Reset while waiting in MEM drops the request.
        @(negedge CLK);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h8000_3008;
        @(negedge CLK);
        i_req = 1'b0;
        chk("rstmem.mem_req", o_mem_req, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rstmem.busy",     o_busy,      0);
        chk("rstmem.mem_req",  o_mem_req,   0);
        chk("rstmem.mem_addr", o_mem_addr,  0);
        chk("rstmem.rdata",    o_rdata,     0);
        chk("rstmem.err",      o_err,       0);
        m_rdata = 32'd0; m_buf_valid = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_8888;
        @(negedge CLK);
        i_mem_ack = 1'b0;
        chk("rstmem.stray_busy", o_busy, 0);
        txn("post_rst", 1'b0, 32'h8000_3008, 32'h0, 2, 32'h0ABC_DEF1, 1'b0, 1'b0);

        // Randomized traffic over a few words so buffer hits and write-through occur.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          k;
            a = 32'h8000_1000 + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
            txn("random", 1'($urandom_range(0, 2) == 0), a, $urandom, k, $urandom,
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
